// File: rtl/pipe_ctrl_stage_if.sv
// Bundle of control/data pipeline signals between an upstream driver and one
// inter-stage register block.
interface pipe_ctrl_stage_if #(
    parameter int CTRL_W = 7,
    parameter int DATA_W = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic              stall;
    logic              flush;
    logic              clr_cnt;
    logic              valid_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] data_out;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output stall, flush, clr_cnt, valid_in, ctrl_in, data_in,
        input  valid_out, ctrl_out, data_out, occupancy, stall_cnt
    );

    modport slave (
        input  stall, flush, clr_cnt, valid_in, ctrl_in, data_in,
        output valid_out, ctrl_out, data_out, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_stage.sv
// Inter-stage pipeline register with valid bits, stall/flush, bubble scrubbing
// of the control bundle, occupancy count and a saturating stall counter.
module pipe_ctrl_stage #(
    parameter int                CTRL_W      = 7,
    parameter int                DATA_W      = 32,
    parameter int                STAGES      = 1,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                CNT_W       = 16
) (
    input logic clk,
    input logic rst,
    pipe_ctrl_stage_if.slave bus
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0]             vldPipe, vldNext;
    logic [STAGES-1:0][CTRL_W-1:0] ctrlPipe, ctrlNext;
    logic [STAGES-1:0][DATA_W-1:0] dataPipe, dataNext;
    logic [OCC_W-1:0]              occQ, occNext;
    logic [CNT_W-1:0]              stallCnt;

    // Invalid slots always carry BUBBLE_CTRL/0 so a squashed entry can never
    // assert RegWEn/MemRW downstream, and X on unused inputs never enters.
    always_comb begin
        vldNext  = vldPipe;
        ctrlNext = ctrlPipe;
        dataNext = dataPipe;
        if (bus.flush) begin
            vldNext = '0;
            dataNext = '0;
            for (int i = 0; i < STAGES; i++) ctrlNext[i] = BUBBLE_CTRL;
        end else if (!bus.stall) begin
            vldNext[0]  = bus.valid_in;
            ctrlNext[0] = bus.valid_in ? bus.ctrl_in : BUBBLE_CTRL;
            dataNext[0] = bus.valid_in ? bus.data_in : '0;
            for (int i = 1; i < STAGES; i++) begin
                vldNext[i]  = vldPipe[i-1];
                ctrlNext[i] = ctrlPipe[i-1];
                dataNext[i] = dataPipe[i-1];
            end
        end
    end

    always_comb begin
        occNext = '0;
        for (int i = 0; i < STAGES; i++) occNext = occNext + OCC_W'(vldNext[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vldPipe  <= '0;
            dataPipe <= '0;
            occQ     <= '0;
            for (int i = 0; i < STAGES; i++) ctrlPipe[i] <= BUBBLE_CTRL;
        end else begin
            vldPipe  <= vldNext;
            ctrlPipe <= ctrlNext;
            dataPipe <= dataNext;
            occQ     <= occNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt)
            stallCnt <= '0;
        else if (bus.stall && !bus.flush && stallCnt != {CNT_W{1'b1}})
            stallCnt <= stallCnt + CNT_W'(1);
    end

    assign bus.valid_out = vldPipe[STAGES-1];
    assign bus.ctrl_out  = ctrlPipe[STAGES-1];
    assign bus.data_out  = dataPipe[STAGES-1];
    assign bus.occupancy = occQ;
    assign bus.stall_cnt = stallCnt;
endmodule
